writeback_unit: RTL and testbench

- Writeback stage between execute and the register bank write port.
- Buffers execute results in a small FIFO and drains them one at a time into the bank's toggle-triggered write port. Each write is committed by flipping `triggerOutw`; address and data are held stable around every flip.
- Results targeting r15 are diverted to fetch as a branch instead of a bank write.
- Also owns the 4-bit NZCV flags register and a pending-write scoreboard that issue uses for hazard checks.

---
 rtl/writeback_unit.sv | 186 ++++++++++++++++++
 tb/tb_writeback_unit.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Writeback stage: queues execute results and drains them one at a time into
// the register bank's toggle-triggered write port. Writes to r15 become a
// one-cycle branch to fetch. Also owns NZCV flags and the pending-write mask
// that issue uses for hazard checks.
//
// state  | meaning
// IDLE   | waiting for a queued result; pops the head when one is present
// SETUP  | addrw/dataOut loaded, trigger flips on the way out
// HOLD   | address/data held stable for HOLD_CYCLES after the flip
// BRANCH | r15 result presented to fetch for exactly one cycle
module writeback_unit #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        resValid,
  output logic        resReady,
  input  logic [3:0]  resAddr,
  input  logic [31:0] resData,
  input  logic        resFlagsWe,
  input  logic [3:0]  resFlags,
  output logic [3:0]  addrw,
  output logic [31:0] dataOut,
  output logic        triggerOutw,
  output logic        branchValid,
  output logic [31:0] branchTarget,
  output logic [3:0]  flagsOut,
  output logic [15:0] pendingMask,
  output logic        busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int HC_W  = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_BRANCH = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic [3:0]         r_q_addr  [DEPTH];
  logic [31:0]        r_q_data  [DEPTH];
  logic               r_q_fwe   [DEPTH];
  logic [3:0]         r_q_flags [DEPTH];

  logic [3:0]         r_cur_addr;
  logic               r_cur_fwe;
  logic [3:0]         r_cur_flags;
  logic [HC_W-1:0]    r_hold_cnt;

  logic [3:0]         r_addrw;
  logic [31:0]        r_data_out;
  logic               r_trigger;
  logic               r_branch_valid;
  logic [31:0]        r_branch_target;
  logic [3:0]         r_flags;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [3:0]         w_head_addr;
  logic [31:0]        w_head_data;
  logic               w_head_fwe;
  logic [3:0]         w_head_flags;
  logic [PTR_W-1:0]   w_off;
  logic [15:0]        w_pending;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  // No pass-through: a full FIFO refuses even if the head pops this edge.
  assign w_push  = resValid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;

  assign w_head_addr  = r_q_addr[r_rd_ptr];
  assign w_head_data  = r_q_data[r_rd_ptr];
  assign w_head_fwe   = r_q_fwe[r_rd_ptr];
  assign w_head_flags = r_q_flags[r_rd_ptr];

  // FIFO storage; contents are only meaningful under the count, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr]  <= resAddr;
      r_q_data[r_wr_ptr]  <= resData;
      r_q_fwe[r_wr_ptr]   <= resFlagsWe;
      r_q_flags[r_wr_ptr] <= resFlags;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Drain FSM with registered bank-port, branch and flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_cur_addr      <= '0;
      r_cur_fwe       <= 1'b0;
      r_cur_flags     <= '0;
      r_hold_cnt      <= '0;
      r_addrw         <= '0;
      r_data_out      <= '0;
      r_trigger       <= 1'b0;
      r_branch_valid  <= 1'b0;
      r_branch_target <= '0;
      r_flags         <= '0;
    end else begin
      r_branch_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cur_addr  <= w_head_addr;
            r_cur_fwe   <= w_head_fwe;
            r_cur_flags <= w_head_flags;
            if (w_head_addr == 4'd15) begin
              r_branch_target <= w_head_data;
              r_branch_valid  <= 1'b1;
              if (w_head_fwe) r_flags <= w_head_flags;
              r_state <= S_BRANCH;
            end else begin
              r_addrw    <= w_head_addr;
              r_data_out <= w_head_data;
              r_state    <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          r_trigger  <= ~r_trigger;
          if (r_cur_fwe) r_flags <= r_cur_flags;
          r_hold_cnt <= HC_W'(HOLD_CYCLES);
          r_state    <= S_HOLD;
        end
        S_HOLD: begin
          if (r_hold_cnt <= HC_W'(1)) r_state <= S_IDLE;
          else                        r_hold_cnt <= r_hold_cnt - HC_W'(1);
        end
        S_BRANCH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Pending writes: every live FIFO slot plus the entry currently draining.
  always_comb begin
    w_pending = '0;
    w_off     = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_off = PTR_W'(j) - r_rd_ptr;
      if (CNT_W'(w_off) < r_count) w_pending[r_q_addr[j]] = 1'b1;
    end
    if (r_state != S_IDLE) w_pending[r_cur_addr] = 1'b1;
  end

  assign resReady     = !w_full;
  assign addrw        = r_addrw;
  assign dataOut      = r_data_out;
  assign triggerOutw  = r_trigger;
  assign branchValid  = r_branch_valid;
  assign branchTarget = r_branch_target;
  assign flagsOut     = r_flags;
  assign pendingMask  = w_pending;
  assign busy         = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus a randomized stream
// checked against an in-order commit model (bank writes, branches, flags).
module tb_writeback_unit;

  localparam int DEPTH = 4;
  localparam int H     = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        resValid;
  logic        resReady;
  logic [3:0]  resAddr;
  logic [31:0] resData;
  logic        resFlagsWe;
  logic [3:0]  resFlags;
  logic [3:0]  addrw;
  logic [31:0] dataOut;
  logic        triggerOutw;
  logic        branchValid;
  logic [31:0] branchTarget;
  logic [3:0]  flagsOut;
  logic [15:0] pendingMask;
  logic        busy;

  writeback_unit #(.DEPTH(DEPTH), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .resValid(resValid), .resReady(resReady), .resAddr(resAddr),
    .resData(resData), .resFlagsWe(resFlagsWe), .resFlags(resFlags),
    .addrw(addrw), .dataOut(dataOut), .triggerOutw(triggerOutw),
    .branchValid(branchValid), .branchTarget(branchTarget),
    .flagsOut(flagsOut), .pendingMask(pendingMask), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] a; logic [31:0] d; logic fwe; logic [3:0] f; } ent_t;
  typedef struct { logic [3:0] a; logic [31:0] d; logic [3:0] f; int c; int chg; } wr_t;
  typedef struct { logic [31:0] t; logic [3:0] f; int c; } br_t;

  ent_t model_q[$];
  wr_t  wq[$];
  br_t  bq[$];
  ent_t stream[$];
  int   acc_cyc[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Bank-side observer: every trigger edge outside reset is one write.
  logic        prev_trig = 1'b0;
  logic [35:0] prev_ad   = '0;
  int          last_chg  = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_trig = 1'b0;
      prev_ad   = '0;
      last_chg  = cyc;
    end else begin
      if ({addrw, dataOut} != prev_ad) begin
        prev_ad  = {addrw, dataOut};
        last_chg = cyc;
      end
      if (triggerOutw != prev_trig) begin
        wq.push_back('{addrw, dataOut, flagsOut, cyc, last_chg});
        prev_trig = triggerOutw;
      end
      if (branchValid) bq.push_back('{branchTarget, flagsOut, cyc});
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_q.delete(); wq.delete(); bq.delete();
  endtask

  // Offer one entry until accepted; returns just after the accepting edge.
  task automatic push_wait(input logic [3:0] a, input logic [31:0] d,
                           input logic fwe, input logic [3:0] f);
    int n = 0;
    @(negedge clk);
    resValid = 1'b1; resAddr = a; resData = d; resFlagsWe = fwe; resFlags = f;
    while (!resReady && n < 200) begin @(negedge clk); n++; end
    n_tests++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL push_timeout: resReady stayed %b, need 1", resReady);
    end
    @(posedge clk); #1;
    resValid = 1'b0;
    model_q.push_back('{a, d, fwe, f});
  endtask

  // Hold resValid high through the whole stream, recording accept edges.
  task automatic push_stream();
    int k = 0;
    int n = 0;
    logic rdy;
    acc_cyc.delete();
    while (k < stream.size() && n < 200) begin
      @(negedge clk);
      resValid = 1'b1; resAddr = stream[k].a; resData = stream[k].d;
      resFlagsWe = stream[k].fwe; resFlags = stream[k].f;
      rdy = resReady;
      @(posedge clk); #1;
      if (rdy) begin
        acc_cyc.push_back(cyc);
        model_q.push_back(stream[k]);
        k++;
      end
      n++;
    end
    resValid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 400) begin @(posedge clk); #1; n++; end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; resValid = 1'b0; resAddr = '0; resData = '0;
    resFlagsWe = 1'b0; resFlags = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({addrw, dataOut, triggerOutw, branchValid, branchTarget, flagsOut} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: addrw=%h data=%h trig=%b bv=%b bt=%h fl=%h, need all 0",
               addrw, dataOut, triggerOutw, branchValid, branchTarget, flagsOut);
    end
    n_tests++;
    if ({resReady, busy, pendingMask} !== {1'b1, 1'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_status: ready=%b busy=%b pm=%h, need 1 0 0000", resReady, busy, pendingMask);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int n;
    wq.delete();
    push_wait(4'd3, 32'h1234_5678, 1'b0, 4'h0);
    n_tests++;
    if (pendingMask !== 16'h0008 || busy !== 1'b1 || addrw !== 4'd0) begin
      n_fail++;
      $display("FAIL single_e0: pm=%h busy=%b addrw=%h, need 0008 1 0", pendingMask, busy, addrw);
    end
    @(posedge clk); #1;
    n_tests++;
    if (addrw !== 4'd3 || dataOut !== 32'h1234_5678 || triggerOutw !== 1'b0) begin
      n_fail++;
      $display("FAIL single_e1: addrw=%h data=%h trig=%b, need 3 12345678 0", addrw, dataOut, triggerOutw);
    end
    @(posedge clk); #1;
    n_tests++;
    if (triggerOutw !== 1'b1 || pendingMask !== 16'h0008) begin
      n_fail++;
      $display("FAIL single_e2: trig=%b pm=%h, need 1 0008", triggerOutw, pendingMask);
    end
    @(posedge clk); #1;
    n_tests++;
    if (pendingMask !== 16'h0008 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_e3: pm=%h busy=%b, need 0008 1", pendingMask, busy);
    end
    @(posedge clk); #1;
    n_tests++;
    if (pendingMask !== 16'h0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_e4: pm=%h busy=%b, need 0000 0", pendingMask, busy);
    end
    wait_idle(n);
    n_tests++;
    if (wq.size() != 1) begin
      n_fail++;
      $display("FAIL single_writes: got %0d writes, need 1", wq.size());
    end
  endtask

  // Shared drain check for stream scenarios: order, data, spacing, stability.
  task automatic test_stream_drain(input string tag);
    int n;
    n = 0;
    while (wq.size() < stream.size() && n < 200) begin @(posedge clk); n++; end
    wait_idle(n);
    repeat (4) @(negedge clk);
    n_tests++;
    if (wq.size() != stream.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d toggles, need %0d", tag, wq.size(), stream.size());
    end
    for (int k = 0; k < stream.size() && k < wq.size(); k++) begin
      n_tests++;
      if (wq[k].a !== stream[k].a || wq[k].d !== stream[k].d) begin
        n_fail++;
        $display("FAIL %s_order[%0d]: got %h/%h, need %h/%h", tag, k, wq[k].a, wq[k].d, stream[k].a, stream[k].d);
      end
      if (k > 0) begin
        n_tests++;
        if (wq[k].c - wq[k-1].c != H + 2 || wq[k].chg - wq[k-1].c < H + 1 || wq[k].c - wq[k].chg < 1) begin
          n_fail++;
          $display("FAIL %s_timing[%0d]: spacing %0d chg_after_prev %0d setup %0d, need %0d >=%0d >=1",
                   tag, k, wq[k].c - wq[k-1].c, wq[k].chg - wq[k-1].c, wq[k].c - wq[k].chg, H + 2, H + 1);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    wq.delete(); stream.delete();
    for (int k = 0; k < 5; k++)
      stream.push_back('{4'($urandom_range(0, 14)), $urandom, 1'b0, 4'h0});
    push_stream();
    n_tests++;
    if (acc_cyc.size() != 5 || acc_cyc[4] - acc_cyc[0] != 4) begin
      n_fail++;
      $display("FAIL b2b_accept: %0d accepted, span %0d, need 5 and 4", acc_cyc.size(),
               acc_cyc.size() == 5 ? acc_cyc[4] - acc_cyc[0] : -1);
    end
    n_tests++;
    if (resReady !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_full_ready: resReady=%b with 4 queued, need 0", resReady);
    end
    test_stream_drain("b2b");
  endtask

  task automatic test_full_pop();
    wq.delete(); stream.delete();
    for (int k = 0; k < 6; k++)
      stream.push_back('{4'($urandom_range(0, 14)), $urandom, 1'b0, 4'h0});
    push_stream();
    n_tests++;
    if (acc_cyc.size() != 6 || acc_cyc[5] - acc_cyc[0] != 6) begin
      n_fail++;
      $display("FAIL fullpop_accept: %0d accepted, 6th at +%0d, need 6 at +6", acc_cyc.size(),
               acc_cyc.size() == 6 ? acc_cyc[5] - acc_cyc[0] : -1);
    end
    test_stream_drain("fullpop");
  endtask

  task automatic test_branch();
    logic t0;
    int n;
    wq.delete(); bq.delete();
    t0 = triggerOutw;
    push_wait(4'd15, 32'h0000_0100, 1'b1, 4'hA);
    @(posedge clk); #1;
    n_tests++;
    if (branchValid !== 1'b1 || branchTarget !== 32'h100 || flagsOut !== 4'hA || pendingMask !== 16'h8000) begin
      n_fail++;
      $display("FAIL branch_e1: bv=%b bt=%h fl=%h pm=%h, need 1 00000100 a 8000",
               branchValid, branchTarget, flagsOut, pendingMask);
    end
    @(posedge clk); #1;
    n_tests++;
    if (branchValid !== 1'b0 || pendingMask !== 16'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_e2: bv=%b pm=%h busy=%b, need 0 0000 0", branchValid, pendingMask, busy);
    end
    wait_idle(n);
    repeat (4) @(negedge clk);
    n_tests++;
    if (triggerOutw !== t0 || wq.size() != 0 || bq.size() != 1 || flagsOut !== 4'hA) begin
      n_fail++;
      $display("FAIL branch_after: trig=%b writes=%0d branches=%0d fl=%h, need %b 0 1 a",
               triggerOutw, wq.size(), bq.size(), flagsOut, t0);
    end
  endtask

  task automatic test_duplicate();
    int n;
    wq.delete();
    push_wait(4'd1, 32'hAA, 1'b0, 4'h0);
    push_wait(4'd1, 32'hBB, 1'b0, 4'h0);
    // The first push is one edge back; bit 1 holds until the second HOLD exits.
    for (int i = 1; i <= 2 * (H + 2); i++) begin
      n_tests++;
      if (pendingMask[1] !== (i < 2 * (H + 2))) begin
        n_fail++;
        $display("FAIL dup_pending[e%0d]: bit1=%b, need %b", i, pendingMask[1], i < 2 * (H + 2));
      end
      @(posedge clk); #1;
    end
    wait_idle(n);
    n_tests++;
    if (wq.size() != 2 || wq[0].d !== 32'hAA || wq[1].d !== 32'hBB || wq[1].a !== 4'd1) begin
      n_fail++;
      $display("FAIL dup_writes: %0d writes, data %h %h, need 2 writes aa bb",
               wq.size(), wq.size() > 0 ? wq[0].d : 32'hx, wq.size() > 1 ? wq[1].d : 32'hx);
    end
  endtask

  task automatic test_reset_mid();
    push_wait(4'd2, 32'h1111, 1'b1, 4'h5);
    push_wait(4'd4, 32'h2222, 1'b0, 4'h0);
    push_wait(4'd6, 32'h3333, 1'b0, 4'h0);
    n_tests++;
    if (busy !== 1'b1 || pendingMask !== 16'h0054 || flagsOut !== 4'h5) begin
      n_fail++;
      $display("FAIL rstmid_before: busy=%b pm=%h fl=%h, need 1 0054 5", busy, pendingMask, flagsOut);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({addrw, dataOut, triggerOutw, branchValid, branchTarget, flagsOut, pendingMask, busy} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_now: addrw=%h data=%h trig=%b bt=%h fl=%h pm=%h busy=%b, need all 0",
               addrw, dataOut, triggerOutw, branchTarget, flagsOut, pendingMask, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wq.delete(); bq.delete(); model_q.delete();
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (wq.size() != 0 || pendingMask !== 16'h0 || triggerOutw !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: writes=%0d pm=%h trig=%b busy=%b, need 0 0000 0 0",
               wq.size(), pendingMask, triggerOutw, busy);
    end
  endtask

  task automatic test_random();
    int n, wi, bi;
    logic [3:0] exp_flags;
    apply_reset();
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      push_wait(($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom_range(0, 14)),
                $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    wait_idle(n);
    repeat (3) @(negedge clk);
    n_tests++;
    if (n >= 400 || busy !== 1'b0 || pendingMask !== 16'h0) begin
      n_fail++;
      $display("FAIL rand_drain: busy=%b pm=%h after %0d cycles, need 0 0000", busy, pendingMask, n);
    end
    exp_flags = 4'h0; wi = 0; bi = 0;
    foreach (model_q[k]) begin
      if (model_q[k].fwe) exp_flags = model_q[k].f;
      n_tests++;
      if (model_q[k].a == 4'd15) begin
        if (bi >= bq.size() || bq[bi].t !== model_q[k].d || bq[bi].f !== exp_flags) begin
          n_fail++;
          $display("FAIL rand_branch[%0d]: got %h/%h, need %h/%h", bi,
                   bi < bq.size() ? bq[bi].t : 32'hx, bi < bq.size() ? bq[bi].f : 4'hx, model_q[k].d, exp_flags);
        end
        bi++;
      end else begin
        if (wi >= wq.size() || wq[wi].a !== model_q[k].a || wq[wi].d !== model_q[k].d || wq[wi].f !== exp_flags) begin
          n_fail++;
          $display("FAIL rand_write[%0d]: got %h/%h/%h, need %h/%h/%h", wi,
                   wi < wq.size() ? wq[wi].a : 4'hx, wi < wq.size() ? wq[wi].d : 32'hx,
                   wi < wq.size() ? wq[wi].f : 4'hx, model_q[k].a, model_q[k].d, exp_flags);
        end
        if (wi > 0 && wi < wq.size()) begin
          n_tests++;
          if (wq[wi].c - wq[wi-1].c < H + 2) begin
            n_fail++;
            $display("FAIL rand_spacing[%0d]: %0d cycles, need >=%0d", wi, wq[wi].c - wq[wi-1].c, H + 2);
          end
        end
        wi++;
      end
    end
    n_tests++;
    if (wq.size() != wi || bq.size() != bi || flagsOut !== exp_flags) begin
      n_fail++;
      $display("FAIL rand_totals: writes %0d branches %0d flags %h, need %0d %0d %h",
               wq.size(), bq.size(), flagsOut, wi, bi, exp_flags);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_pop();
    test_branch();
    test_duplicate();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
